// File: rtl/memory_cache_request_issue.sv
// memory_cache_request_issue: buffers MemoryPacket requests, maps them onto the cache IOB port and returns read responses.
// Optional macro MEMORY_CACHE_WRITE_ACK_EN: writes also return a response carrying the original write data.
`default_nettype none

package memory_cache_request_issue_pkg;
  localparam int M_AXI4_FE_ADDR_W = 32;
  localparam int M_AXI4_FE_DATA_W = 32;
  localparam int M_AXI4_FE_STRB_W = M_AXI4_FE_DATA_W / 8;

  localparam logic [1:0] CMD_INVALID      = 2'd0;
  localparam logic [1:0] CMD_MEM_READ     = 2'd1;
  localparam logic [1:0] CMD_MEM_WRITE    = 2'd2;
  localparam logic [1:0] CMD_MEM_RESPONSE = 2'd3;

  typedef struct packed {
    logic [7:0] source;
    logic [7:0] destination;
  } MemoryPacketRoute;

  typedef struct packed {
    logic [7:0]                  id_buffer;
    logic [M_AXI4_FE_ADDR_W-1:0] offset;
  } MemoryPacketAddress;

  typedef struct packed {
    logic [1:0] cmd;
    logic [3:0] tag;
  } MemoryPacketSubclass;

  typedef struct packed {
    MemoryPacketRoute    route;
    MemoryPacketAddress  address;
    MemoryPacketSubclass subclass;
  } MemoryPacketMeta;

  typedef struct packed {
    logic [M_AXI4_FE_DATA_W-1:0] field;
  } MemoryPacketData;

  typedef struct packed {
    logic            valid;
    MemoryPacketMeta meta;
    MemoryPacketData data;
  } MemoryPacket;

  typedef struct packed {
    MemoryPacketMeta meta;
    MemoryPacketData data;
  } MemoryPacketPayload;

  typedef struct packed {
    logic                        valid;
    logic [M_AXI4_FE_ADDR_W-1:0] buffer_0;
    logic [M_AXI4_FE_ADDR_W-1:0] buffer_1;
    logic [M_AXI4_FE_ADDR_W-1:0] buffer_2;
    logic [M_AXI4_FE_ADDR_W-1:0] buffer_3;
    logic [M_AXI4_FE_ADDR_W-1:0] buffer_4;
    logic [M_AXI4_FE_ADDR_W-1:0] buffer_5;
    logic [M_AXI4_FE_ADDR_W-1:0] buffer_6;
    logic [M_AXI4_FE_ADDR_W-1:0] buffer_7;
    logic [M_AXI4_FE_ADDR_W-1:0] buffer_8;
  } KernelDescriptor;

  typedef struct packed {
    logic empty;
    logic prog_full;
  } FIFOStateSignalsOutput;

  typedef struct packed {
    logic                        valid;
    logic [M_AXI4_FE_ADDR_W-1:0] addr;
    logic [M_AXI4_FE_DATA_W-1:0] wdata;
    logic [M_AXI4_FE_STRB_W-1:0] wstrb;
  } CacheRequestIOB;
endpackage

module memory_cache_request_issue
  import memory_cache_request_issue_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH      = 16,
  parameter int PROG_FULL_THRESHOLD = 12
) (
  input  logic                        ap_clk,
  input  logic                        areset_n,
  input  KernelDescriptor             descriptor_in,
  input  MemoryPacket                 request_in,
  output FIFOStateSignalsOutput       fifo_request_signals_out,
  output MemoryPacket                 response_out,
  input  logic                        response_ready_in,
  output CacheRequestIOB              cache_iob_out,
  input  logic                        cache_iob_ready_in,
  input  logic [M_AXI4_FE_DATA_W-1:0] cache_iob_rdata_in,
  output logic                        overflow_error_out,
  output logic                        idle_out
);

  localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
`ifdef MEMORY_CACHE_WRITE_ACK_EN
  localparam logic WRITE_ACK = 1'b1;
`else
  localparam logic WRITE_ACK = 1'b0;
`endif

  logic [1:0]                  state, state_next;
  KernelDescriptor             desc;
  MemoryPacketPayload          fifo_mem [REQ_FIFO_DEPTH];
  logic [PTR_W:0]              wr_ptr, rd_ptr, count;
  logic                        empty, full, push, pop;
  MemoryPacketPayload          head;
  logic                        head_read, head_write;
  logic [M_AXI4_FE_ADDR_W-1:0] base;
  MemoryPacketMeta             issue_meta;
  logic [M_AXI4_FE_ADDR_W-1:0] issue_addr;
  logic [M_AXI4_FE_DATA_W-1:0] issue_wdata;
  logic [M_AXI4_FE_STRB_W-1:0] issue_wstrb;
  logic                        issue_read;
  logic [M_AXI4_FE_DATA_W-1:0] resp_data;

  // Extra pointer bit distinguishes full from empty; the latched desc.valid gates popping.
  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign full       = (count == (PTR_W+1)'(REQ_FIFO_DEPTH));
  assign pop        = (state == IDLE) && !empty && desc.valid;
  assign push       = request_in.valid && (!full || pop);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign head_read  = (head.meta.subclass.cmd == CMD_MEM_READ);
  assign head_write = (head.meta.subclass.cmd == CMD_MEM_WRITE);

  always_comb begin
    base = desc.buffer_0;
    case (head.meta.address.id_buffer)
      8'h01:   base = desc.buffer_1;
      8'h02:   base = desc.buffer_2;
      8'h04:   base = desc.buffer_3;
      8'h08:   base = desc.buffer_4;
      8'h10:   base = desc.buffer_5;
      8'h20:   base = desc.buffer_6;
      8'h40:   base = desc.buffer_7;
      8'h80:   base = desc.buffer_8;
      default: base = desc.buffer_0;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {request_in.meta, request_in.data};
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      overflow_error_out <= 1'b0;
      desc               <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (request_in.valid && !push) overflow_error_out <= 1'b1;
      if (descriptor_in.valid) desc <= descriptor_in;
    end
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      issue_meta  <= '0;
      issue_addr  <= '0;
      issue_wdata <= '0;
      issue_wstrb <= '0;
      issue_read  <= 1'b0;
      resp_data   <= '0;
    end else begin
      if (pop) begin
        issue_meta  <= head.meta;
        issue_addr  <= base + head.meta.address.offset;
        issue_wdata <= head.data.field;
        issue_wstrb <= head_write ? '1 : '0;
        issue_read  <= head_read;
      end
      if (state == ISSUE && cache_iob_ready_in)
        resp_data <= issue_read ? cache_iob_rdata_in : issue_wdata;
    end
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop && (head_read || head_write)) state_next = ISSUE;
      ISSUE:   if (cache_iob_ready_in) state_next = (issue_read || WRITE_ACK) ? RESP : IDLE;
      RESP:    if (response_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cache_iob_out = '0;
    response_out  = '0;
    if (state == ISSUE) begin
      cache_iob_out.valid = 1'b1;
      cache_iob_out.addr  = issue_addr;
      cache_iob_out.wdata = issue_wdata;
      cache_iob_out.wstrb = issue_wstrb;
    end
    if (state == RESP) begin
      response_out.valid             = 1'b1;
      response_out.meta              = issue_meta;
      response_out.meta.subclass.cmd = CMD_MEM_RESPONSE;
      response_out.data.field        = resp_data;
    end
    fifo_request_signals_out.empty     = empty;
    fifo_request_signals_out.prog_full = (count >= (PTR_W+1)'(PROG_FULL_THRESHOLD));
    idle_out = empty && (state == IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_cache_request_issue.sv
// Testbench for memory_cache_request_issue: directed scenarios plus randomized traffic against a queue-based reference model.
`default_nettype none

module tb_memory_cache_request_issue;
  import memory_cache_request_issue_pkg::*;

`ifdef MEMORY_CACHE_WRITE_ACK_EN
  localparam bit ACK_WRITES = 1'b1;
`else
  localparam bit ACK_WRITES = 1'b0;
`endif

  logic                        ap_clk = 1'b0;
  logic                        areset_n = 1'b0;
  KernelDescriptor             descriptor_in;
  MemoryPacket                 request_in;
  FIFOStateSignalsOutput       fifo_request_signals_out;
  MemoryPacket                 response_out;
  logic                        response_ready_in;
  CacheRequestIOB              cache_iob_out;
  logic                        cache_iob_ready_in;
  logic [M_AXI4_FE_DATA_W-1:0] cache_iob_rdata_in;
  logic                        overflow_error_out;
  logic                        idle_out;

  memory_cache_request_issue #(.REQ_FIFO_DEPTH(16), .PROG_FULL_THRESHOLD(12)) dut (
    .ap_clk                   (ap_clk),
    .areset_n                 (areset_n),
    .descriptor_in            (descriptor_in),
    .request_in               (request_in),
    .fifo_request_signals_out (fifo_request_signals_out),
    .response_out             (response_out),
    .response_ready_in        (response_ready_in),
    .cache_iob_out            (cache_iob_out),
    .cache_iob_ready_in       (cache_iob_ready_in),
    .cache_iob_rdata_in       (cache_iob_rdata_in),
    .overflow_error_out       (overflow_error_out),
    .idle_out                 (idle_out)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            is_read;
    MemoryPacketMeta meta;
  } iob_exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] bench_buf [9];
  iob_exp_t    exp_iob [$];
  MemoryPacket exp_resp [$];

  // Reference mapping: a single set bit k picks buffer k+1, anything else picks buffer 0.
  function automatic logic [31:0] exp_base(input logic [7:0] id);
    logic [31:0] b;
    b = bench_buf[0];
    if ($countones(id) == 1)
      for (int k = 0; k < 8; k++) if (id[k]) b = bench_buf[k+1];
    return b;
  endfunction

  function automatic MemoryPacket make_pkt(input logic [1:0] cmd, input logic [7:0] id,
      input logic [31:0] off, input logic [31:0] data, input logic [7:0] src,
      input logic [7:0] dst, input logic [3:0] tag);
    MemoryPacket p;
    p = '0;
    p.valid = 1'b1;
    p.meta.route.source = src;
    p.meta.route.destination = dst;
    p.meta.address.id_buffer = id;
    p.meta.address.offset = off;
    p.meta.subclass.cmd = cmd;
    p.meta.subclass.tag = tag;
    p.data.field = data;
    return p;
  endfunction

  task automatic drive_idle();
    descriptor_in      = '0;
    request_in         = '0;
    response_ready_in  = 1'b0;
    cache_iob_ready_in = 1'b0;
    cache_iob_rdata_in = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    areset_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    areset_n = 1'b1;
    @(negedge ap_clk);
  endtask

  task automatic set_desc();
    descriptor_in = '{1'b1, bench_buf[0], bench_buf[1], bench_buf[2], bench_buf[3],
                      bench_buf[4], bench_buf[5], bench_buf[6], bench_buf[7], bench_buf[8]};
    @(negedge ap_clk);
    descriptor_in = '0;
  endtask

  task automatic push_pkt(input MemoryPacket p);
    request_in = p;
    @(negedge ap_clk);
    request_in = '0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (fifo_request_signals_out.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", fifo_request_signals_out.empty); end
    tests++; if (fifo_request_signals_out.prog_full !== 1'b0) begin fails++; $display("FAIL reset_prog_full got %b want 0", fifo_request_signals_out.prog_full); end
    tests++; if (idle_out !== 1'b1) begin fails++; $display("FAIL reset_idle got %b want 1", idle_out); end
    tests++; if (cache_iob_out !== '0) begin fails++; $display("FAIL reset_iob got %h want 0", cache_iob_out); end
    tests++; if (response_out !== '0) begin fails++; $display("FAIL reset_resp got %h want 0", response_out); end
    tests++; if (overflow_error_out !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow_error_out); end
  endtask

  task automatic test_descriptor_gating();
    int seen;
    seen = 0;
    push_pkt(make_pkt(CMD_MEM_READ, 8'b10, 32'h40, 32'h0, 8'h5A, 8'h3C, 4'h7));
    repeat (8) begin
      if (cache_iob_out.valid) seen++;
      @(negedge ap_clk);
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL gate_no_issue got %0d valid cycles want 0", seen); end
    tests++; if (fifo_request_signals_out.empty !== 1'b0) begin fails++; $display("FAIL gate_fifo_held got empty=%b want 0", fifo_request_signals_out.empty); end
    for (int k = 0; k < 9; k++) bench_buf[k] = $urandom;
    bench_buf[0] = 32'h0000_2000;
    bench_buf[2] = 32'h1000_0000;
    set_desc();
    @(negedge ap_clk);
    tests++; if (cache_iob_out.valid !== 1'b1) begin fails++; $display("FAIL gate_issue_after_desc got %b want 1", cache_iob_out.valid); end
  endtask

  task automatic test_read();
    tests++; if ({cache_iob_out.addr, cache_iob_out.wstrb} !== {32'h1000_0040, 4'h0}) begin
      fails++; $display("FAIL read_iob got addr=%h wstrb=%h want addr=10000040 wstrb=0", cache_iob_out.addr, cache_iob_out.wstrb); end
    @(negedge ap_clk);
    tests++; if ({cache_iob_out.valid, cache_iob_out.addr} !== {1'b1, 32'h1000_0040}) begin
      fails++; $display("FAIL read_iob_stable got valid=%b addr=%h want 1/10000040", cache_iob_out.valid, cache_iob_out.addr); end
    cache_iob_ready_in = 1'b1;
    cache_iob_rdata_in = 32'hDEAD_BEEF;
    @(negedge ap_clk);
    cache_iob_ready_in = 1'b0;
    cache_iob_rdata_in = '0;
    tests++; if ({response_out.valid, response_out.meta.subclass.cmd, response_out.data.field} !== {1'b1, CMD_MEM_RESPONSE, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL read_resp got v=%b cmd=%0d field=%h want 1/3/deadbeef", response_out.valid, response_out.meta.subclass.cmd, response_out.data.field); end
    tests++; if ({response_out.meta.route, response_out.meta.address, response_out.meta.subclass.tag} !== {8'h5A, 8'h3C, 8'h02, 32'h40, 4'h7}) begin
      fails++; $display("FAIL read_resp_meta got %h want route 5a3c id 02 off 40 tag 7", response_out.meta); end
  endtask

  task automatic test_resp_hold();
    MemoryPacket held;
    int bad;
    held = response_out;
    bad = 0;
    push_pkt(make_pkt(CMD_MEM_WRITE, 8'h00, 32'h8, 32'h1234, 8'h11, 8'h22, 4'h3));
    repeat (4) begin
      if (response_out !== held || cache_iob_out.valid !== 1'b0) bad++;
      @(negedge ap_clk);
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL resp_hold_stable got %0d unstable cycles want 0", bad); end
    tests++; if (fifo_request_signals_out.empty !== 1'b0) begin fails++; $display("FAIL resp_hold_fifo_accept got empty=%b want 0", fifo_request_signals_out.empty); end
    response_ready_in = 1'b1;
    @(negedge ap_clk);
    response_ready_in = 1'b0;
    tests++; if (response_out.valid !== 1'b0) begin fails++; $display("FAIL resp_release got valid=%b want 0", response_out.valid); end
  endtask

  task automatic test_write();
    int seen;
    @(negedge ap_clk);
    tests++; if ({cache_iob_out.valid, cache_iob_out.addr, cache_iob_out.wdata, cache_iob_out.wstrb} !== {1'b1, 32'h2008, 32'h1234, 4'hF}) begin
      fails++; $display("FAIL write_iob got v=%b addr=%h wdata=%h wstrb=%h want 1/2008/1234/f", cache_iob_out.valid, cache_iob_out.addr, cache_iob_out.wdata, cache_iob_out.wstrb); end
    cache_iob_ready_in = 1'b1;
    cache_iob_rdata_in = 32'hFFFF_0000;
    @(negedge ap_clk);
    cache_iob_ready_in = 1'b0;
    if (ACK_WRITES) begin
      tests++; if ({response_out.valid, response_out.meta.subclass.cmd, response_out.data.field} !== {1'b1, CMD_MEM_RESPONSE, 32'h1234}) begin
        fails++; $display("FAIL write_ack got v=%b cmd=%0d field=%h want 1/3/1234", response_out.valid, response_out.meta.subclass.cmd, response_out.data.field); end
      response_ready_in = 1'b1;
      @(negedge ap_clk);
      response_ready_in = 1'b0;
    end else begin
      seen = 0;
      repeat (5) begin
        if (response_out.valid) seen++;
        @(negedge ap_clk);
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL write_no_resp got %0d resp cycles want 0", seen); end
    end
    tests++; if (idle_out !== 1'b1) begin fails++; $display("FAIL write_idle got %b want 1", idle_out); end
  endtask

  task automatic test_overflow();
    int n;
    int bad;
    do_reset();
    response_ready_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      request_in = make_pkt(CMD_MEM_WRITE, 8'h00, 32'(i * 4), 32'(i), 8'h01, 8'h02, 4'h0);
      @(negedge ap_clk);
      tests++; if (fifo_request_signals_out.prog_full !== (i + 1 >= 12)) begin
        fails++; $display("FAIL ovf_prog_full push=%0d got %b want %b", i + 1, fifo_request_signals_out.prog_full, (i + 1 >= 12)); end
      tests++; if (overflow_error_out !== (i + 1 > 16)) begin
        fails++; $display("FAIL ovf_flag push=%0d got %b want %b", i + 1, overflow_error_out, (i + 1 > 16)); end
    end
    request_in = '0;
    for (int k = 0; k < 9; k++) bench_buf[k] = $urandom;
    bench_buf[0] = 32'h0000_2000;
    set_desc();
    n = 0;
    bad = 0;
    repeat (200) begin
      cache_iob_ready_in = 1'b0;
      if (cache_iob_out.valid && $urandom_range(0, 1) == 1) begin
        if (n >= 16 || cache_iob_out.addr !== 32'h2000 + 32'(n * 4) || cache_iob_out.wdata !== 32'(n)) begin
          bad++; $display("FAIL ovf_order txn=%0d got addr=%h wdata=%h want addr=%h wdata=%h", n, cache_iob_out.addr, cache_iob_out.wdata, 32'h2000 + 32'(n * 4), n);
        end
        cache_iob_ready_in = 1'b1;
        n++;
      end
      @(negedge ap_clk);
    end
    cache_iob_ready_in = 1'b0;
    tests++; if (bad !== 0) fails++;
    tests++; if (n !== 16) begin fails++; $display("FAIL ovf_txn_count got %0d want 16", n); end
    tests++; if ({overflow_error_out, fifo_request_signals_out.empty, idle_out} !== 3'b111) begin
      fails++; $display("FAIL ovf_end got ovf/empty/idle=%b%b%b want 111", overflow_error_out, fifo_request_signals_out.empty, idle_out); end
  endtask

  task automatic test_async_reset();
    int waited;
    int bad;
    response_ready_in = 1'b1;
    push_pkt(make_pkt(CMD_MEM_READ, 8'h00, 32'h100, 32'h0, 8'h09, 8'h08, 4'h1));
    waited = 0;
    while (!cache_iob_out.valid && waited < 10) begin
      @(negedge ap_clk);
      waited++;
    end
    tests++; if (cache_iob_out.valid !== 1'b1) begin fails++; $display("FAIL arst_reach_issue got valid=%b want 1", cache_iob_out.valid); end
    #2 areset_n = 1'b0;
    #1;
    tests++; if ({cache_iob_out, response_out, overflow_error_out} !== '0 || {fifo_request_signals_out.empty, idle_out} !== 2'b11) begin
      fails++; $display("FAIL arst_immediate got iob=%h resp_v=%b empty=%b idle=%b want iob=0 resp_v=0 empty=1 idle=1", cache_iob_out, response_out.valid, fifo_request_signals_out.empty, idle_out); end
    @(negedge ap_clk);
    @(negedge ap_clk);
    areset_n = 1'b1;
    cache_iob_ready_in = 1'b1;
    bad = 0;
    repeat (6) begin
      if (cache_iob_out.valid || response_out.valid) bad++;
      @(negedge ap_clk);
    end
    cache_iob_ready_in = 1'b0;
    tests++; if (bad !== 0) begin fails++; $display("FAIL arst_stale got %0d active cycles want 0", bad); end
    push_pkt(make_pkt(CMD_MEM_READ, 8'h01, 32'h4, 32'h0, 8'h00, 8'h00, 4'h0));
    bad = 0;
    repeat (5) begin
      if (cache_iob_out.valid) bad++;
      @(negedge ap_clk);
    end
    tests++; if (bad !== 0 || fifo_request_signals_out.empty !== 1'b0) begin
      fails++; $display("FAIL arst_desc_cleared got issue_cycles=%0d empty=%b want 0/0", bad, fifo_request_signals_out.empty); end
  endtask

  task automatic test_random();
    MemoryPacket sendq [$];
    MemoryPacket p;
    MemoryPacket r;
    iob_exp_t    e;
    logic [1:0]  cmds [6];
    logic [7:0]  id;
    int          cyc;
    do_reset();
    cmds = '{CMD_MEM_READ, CMD_MEM_READ, CMD_MEM_WRITE, CMD_MEM_WRITE, CMD_INVALID, CMD_MEM_RESPONSE};
    for (int k = 0; k < 9; k++) bench_buf[k] = $urandom;
    set_desc();
    for (int k = 0; k < 9; k++) bench_buf[k] = $urandom;
    set_desc();
    for (int b = 0; b < 6; b++) begin
      sendq.delete();
      for (int i = 0; i < int'($urandom_range(4, 16)); i++) begin
        case ($urandom_range(0, 3))
          0:       id = 8'h00;
          1:       id = 8'h01 << $urandom_range(0, 7);
          2:       id = 8'($urandom);
          default: id = 8'h80 >> $urandom_range(0, 7);
        endcase
        sendq.push_back(make_pkt(cmds[$urandom_range(0, 5)], id, $urandom, $urandom,
                                 8'($urandom), 8'($urandom), 4'($urandom)));
      end
      cyc = 0;
      while (cyc < 2000) begin
        if (sendq.size() == 0 && exp_iob.size() == 0 && exp_resp.size() == 0 && idle_out) break;
        cache_iob_ready_in = 1'($urandom_range(0, 1));
        cache_iob_rdata_in = $urandom;
        if (cache_iob_out.valid && cache_iob_ready_in) begin
          tests++;
          if (exp_iob.size() == 0) begin
            fails++; $display("FAIL rand_spurious_iob got addr=%h want no transaction", cache_iob_out.addr);
          end else begin
            e = exp_iob.pop_front();
            if ({cache_iob_out.addr, cache_iob_out.wdata, cache_iob_out.wstrb} !== {e.addr, e.wdata, e.wstrb}) begin
              fails++; $display("FAIL rand_iob got %h/%h/%h want %h/%h/%h", cache_iob_out.addr, cache_iob_out.wdata, cache_iob_out.wstrb, e.addr, e.wdata, e.wstrb);
            end
            if (e.is_read || ACK_WRITES) begin
              r = '0;
              r.valid = 1'b1;
              r.meta = e.meta;
              r.meta.subclass.cmd = CMD_MEM_RESPONSE;
              r.data.field = e.is_read ? cache_iob_rdata_in : e.wdata;
              exp_resp.push_back(r);
            end
          end
        end
        response_ready_in = ($urandom_range(0, 2) != 0);
        if (response_out.valid && response_ready_in) begin
          tests++;
          if (exp_resp.size() == 0) begin
            fails++; $display("FAIL rand_spurious_resp got %h want none", response_out);
          end else begin
            r = exp_resp.pop_front();
            if (response_out !== r) begin fails++; $display("FAIL rand_resp got %h want %h", response_out, r); end
          end
        end
        request_in = '0;
        if (sendq.size() != 0 && $urandom_range(0, 2) != 0) begin
          p = sendq.pop_front();
          if (p.meta.subclass.cmd == CMD_MEM_READ || p.meta.subclass.cmd == CMD_MEM_WRITE) begin
            e.addr    = exp_base(p.meta.address.id_buffer) + p.meta.address.offset;
            e.wdata   = p.data.field;
            e.is_read = (p.meta.subclass.cmd == CMD_MEM_READ);
            e.wstrb   = e.is_read ? 4'h0 : 4'hF;
            e.meta    = p.meta;
            exp_iob.push_back(e);
          end
          request_in = p;
        end
        @(negedge ap_clk);
        cyc++;
      end
      request_in = '0;
      tests++; if (exp_iob.size() != 0 || exp_resp.size() != 0 || idle_out !== 1'b1) begin
        fails++; $display("FAIL rand_drain batch=%0d got iob_left=%0d resp_left=%0d idle=%b want 0/0/1", b, exp_iob.size(), exp_resp.size(), idle_out);
        exp_iob.delete();
        exp_resp.delete();
      end
    end
    tests++; if (overflow_error_out !== 1'b0) begin fails++; $display("FAIL rand_no_overflow got %b want 0", overflow_error_out); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_descriptor_gating();
    test_read();
    test_resp_hold();
    test_write();
    test_overflow();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_cache_request_issue.md
Name: memory_cache_request_issue

Overview:
- Downstream consumer of MemoryPacket requests from engine memory ports; upstream driver of the cache frontend IOB port.
- Buffers requests in a FIFO and resolves the buffer base address from the latched KernelDescriptor.
- Issues one blocking IOB transaction at a time and returns read data as a MemoryPacket response with original meta preserved.

Parameters:
- REQ_FIFO_DEPTH, 16, request FIFO entries (power of two, ≥4)
- PROG_FULL_THRESHOLD, 12, occupancy at which fifo_request_signals_out.prog_full asserts

Ports:
- ap_clk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- descriptor_in  in  KernelDescriptor  kernel buffer base pointers; sampled when .valid
- request_in  in  MemoryPacket  request; written to FIFO when .valid
- fifo_request_signals_out  out  FIFOStateSignalsOutput  empty, prog_full of request FIFO
- response_out  out  MemoryPacket  response; held until accepted
- response_ready_in  in  1  downstream accepts response_out when response_out.valid
- cache_iob_out  out  CacheRequestIOB  valid/addr/wdata/wstrb to cache
- cache_iob_ready_in  in  1  cache completion strobe
- cache_iob_rdata_in  in  M_AXI4_FE_DATA_W  cache read data, valid with ready
- overflow_error_out  out  1  sticky: write attempted while FIFO full
- idle_out  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0 except fifo empty=1, idle_out=1; FIFO flushed, descriptor cleared, FSM→IDLE; any in-flight IOB transaction abandoned, no response emitted.
- Descriptor: latched on descriptor_in.valid; the latched copy persists until reset. A later valid overwrites it. No FIFO pop occurs while no descriptor is latched.
- FIFO: push on request_in.valid when not full. Push when full drops the packet and sets overflow_error_out until reset. Simultaneous push and pop when full are allowed; the push is accepted. prog_full = count ≥ PROG_FULL_THRESHOLD.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if FIFO not empty and descriptor latched, pop head and register the mapped IOB fields → ISSUE.
  - ISSUE: cache_iob_out.valid=1, with addr/wdata/wstrb stable until cache_iob_ready_in.
    - On ready with cmd CMD_MEM_READ: capture rdata → RESP.
    - On ready with cmd CMD_MEM_WRITE: → IDLE.
  - RESP: response_out.valid=1 and all response fields stable; on response_ready_in → IDLE.
- Commands other than READ/WRITE: popped, no IOB transaction, no response, FSM stays IDLE.
- Mapping:
  - Base selected by one-hot id_buffer: bit k → buffer_(k+1) for k=0..7. Zero or non-one-hot → buffer_0.
  - addr = base + offset, truncated to M_AXI4_FE_ADDR_W (wraps mod 2^ADDR_W).
  - wdata = data.field.
  - wstrb = all ones for write, 0 otherwise.
- Response: meta copied from request except subclass.cmd = CMD_MEM_RESPONSE; data.field = captured rdata.
- Latency: pop in cycle N; iob valid in N+1; if ready in N+1, response valid in N+2. Minimum 3 cycles per read, 2 per write.
- cache_iob_ready_in outside ISSUE is ignored. response_ready_in outside RESP is ignored.
- idle_out is combinational from FIFO empty and state==IDLE.

Optional Feature:
- MEMORY_CACHE_WRITE_ACK_EN.
  - Defined: on ready for a write, ISSUE→RESP and a response is emitted with cmd CMD_MEM_RESPONSE, meta copied, and data.field = original wdata (rdata ignored).
  - Undefined: writes produce no response, as above.

Test Plan:
- Descriptor buffer_2=0x1000_0000; read with id_buffer=0b10, offset=0x40 → iob addr 0x1000_0040, wstrb 0; cache returns rdata 0xDEAD_BEEF one cycle later → response cmd CMD_MEM_RESPONSE, field 0xDEAD_BEEF, source route unchanged.
- Write with id_buffer=0, offset=0x8, data 0x1234, buffer_0=0x2000 → addr 0x2008, wdata 0x1234, wstrb all ones; no response (macro off) / response field 0x1234 (macro on).
- Push 17 requests with cache_iob_ready_in held low → prog_full at 12 entries; 17th dropped, overflow_error_out=1; release ready → exactly 16 transactions issued, in order.
- response_ready_in held low 5 cycles in RESP → response_out stable; no new IOB issue; FIFO keeps accepting.
- Requests pushed before any descriptor → no IOB activity; descriptor arrives → issue starts the next cycle.
- areset_n low during ISSUE → outputs cleared immediately; after release, FIFO empty, idle_out=1, no stale response.
